// File: rtl/dm_abstract_cmd_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_abstract_cmd_ctrl_pkg: types for the abstract command controller  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dm_abstract_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_REQ   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [15:0] c_gpr_first  = 16'h1000;
  localparam logic [15:0] c_gpr_last   = 16'h101F;
  localparam logic [15:0] c_csr_last   = 16'h0FFF;
  localparam logic [2:0]  c_aarsize_32 = 3'd2;

  typedef struct packed {
    logic        rsvd;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } acc_reg_ctrl_t;

  typedef struct packed {
    logic [7:0]    cmdtype;
    acc_reg_ctrl_t control;
  } command_t;

  typedef struct packed {
    logic [2:0]  rsvd3;
    logic [4:0]  progbufsize;
    logic [10:0] rsvd2;
    logic        busy;
    logic        rsvd1;
    logic [2:0]  cmderr;
    logic [3:0]  rsvd0;
    logic [3:0]  datacount;
  } abstractcs_t;

endpackage
`default_nettype wire

// File: rtl/dm_abstract_cmd_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dm_abstract_cmd_ctrl: Access Register abstract command sequencer     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dm_abstract_cmd_ctrl
  import dm_abstract_cmd_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 255,
  parameter int unsigned DATACOUNT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dmactive,
  input  logic        cmd_wr,
  input  logic [31:0] cmd_wdata,
  input  logic        acs_wr,
  input  logic [31:0] acs_wdata,
  output logic [31:0] acs_rdata,
  input  logic        data0_wr,
  input  logic [31:0] data0_wdata,
  output logic [31:0] data0_rdata,
  input  logic        hart_halted,
  output logic        reg_req,
  output logic        reg_we,
  output logic        reg_is_csr,
  output logic [11:0] reg_addr,
  output logic [31:0] reg_wdata,
  input  logic        reg_ack,
  input  logic        reg_err,
  input  logic [31:0] reg_rdata
);

  localparam int unsigned      CNT_W      = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  command_t         cmd_q, cmd_d;
  cmderr_e          cmderr_q, cmderr_d;
  logic [31:0]      data0_q, data0_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reg_we_q, reg_we_d;
  logic             reg_is_csr_q, reg_is_csr_d;
  logic [11:0]      reg_addr_q, reg_addr_d;

  logic        w_busy, w_cmd_accept, w_timeout_hit, w_err_set;
  logic        w_chk_go_req, w_chk_is_csr;
  logic [11:0] w_chk_addr;
  cmderr_e     w_chk_err, w_err_val;
  abstractcs_t w_acs;
  logic        w_unused;

  assign w_busy        = (state_q != ST_IDLE);
  assign w_cmd_accept  = (state_q == ST_IDLE) && cmd_wr && (cmderr_q == CMDERR_NONE);
  assign w_timeout_hit = (state_q == ST_REQ) && !reg_ack && (cnt_q == c_cnt_last);
  assign w_unused      = ^{acs_wdata[31:11], acs_wdata[7:0], cmd_q.control.rsvd};

  // Validation of the latched command, in priority order.
  always_comb begin
    w_chk_err    = CMDERR_NONE;
    w_chk_go_req = 1'b0;
    w_chk_is_csr = 1'b0;
    w_chk_addr   = '0;
    if (cmd_q.cmdtype != 8'd0 || cmd_q.control.postexec ||
        (cmd_q.control.transfer && cmd_q.control.aarsize != c_aarsize_32)) begin
      w_chk_err = CMDERR_NOTSUP;
    end else if (cmd_q.control.transfer) begin
      if (!hart_halted) begin
        w_chk_err = CMDERR_HALTRESUME;
      end else if (cmd_q.control.regno >= c_gpr_first && cmd_q.control.regno <= c_gpr_last) begin
        w_chk_go_req = 1'b1;
        w_chk_addr   = {7'd0, cmd_q.control.regno[4:0]};
      end else if (cmd_q.control.regno <= c_csr_last) begin
        w_chk_go_req = 1'b1;
        w_chk_is_csr = 1'b1;
        w_chk_addr   = cmd_q.control.regno[11:0];
      end else begin
        w_chk_err = CMDERR_EXCEPTION;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !dmactive) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      cmderr_q     <= CMDERR_NONE;
      data0_q      <= '0;
      cnt_q        <= '0;
      reg_we_q     <= 1'b0;
      reg_is_csr_q <= 1'b0;
      reg_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      cmderr_q     <= cmderr_d;
      data0_q      <= data0_d;
      cnt_q        <= cnt_d;
      reg_we_q     <= reg_we_d;
      reg_is_csr_q <= reg_is_csr_d;
      reg_addr_q   <= reg_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (w_cmd_accept) state_d = ST_CHECK;
      ST_CHECK: state_d = w_chk_go_req ? ST_REQ : ST_DONE;
      ST_REQ:   if (reg_ack || w_timeout_hit) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_d        = cmd_q;
    data0_d      = data0_q;
    cnt_d        = cnt_q;
    reg_we_d     = reg_we_q;
    reg_is_csr_d = reg_is_csr_q;
    reg_addr_d   = reg_addr_q;
    w_err_set    = 1'b0;
    w_err_val    = CMDERR_NONE;
    unique case (state_q)
      ST_IDLE: begin
        if (w_cmd_accept) begin
          cmd_d = command_t'(cmd_wdata);
          cnt_d = '0;
        end
        if (data0_wr) data0_d = data0_wdata;
      end
      ST_CHECK: begin
        if (w_chk_err != CMDERR_NONE) begin
          w_err_set = 1'b1;
          w_err_val = w_chk_err;
        end
        if (w_chk_go_req) begin
          reg_we_d     = cmd_q.control.write;
          reg_is_csr_d = w_chk_is_csr;
          reg_addr_d   = w_chk_addr;
        end
      end
      ST_REQ: begin
        if (reg_ack) begin
          if (reg_err) begin
            w_err_set = 1'b1;
            w_err_val = CMDERR_EXCEPTION;
          end else if (!reg_we_q) begin
            data0_d = reg_rdata;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (w_timeout_hit) begin
            w_err_set = 1'b1;
            w_err_val = CMDERR_EXCEPTION;
          end
        end
      end
      ST_DONE: begin
        if (cmd_q.control.aarpostincrement && cmderr_q == CMDERR_NONE)
          cmd_d.control.regno = cmd_q.control.regno + 16'd1;
      end
      default: ;
    endcase
    if (!w_err_set && w_busy && (cmd_wr || data0_wr)) begin
      w_err_set = 1'b1;
      w_err_val = CMDERR_BUSY;
    end
    // A freshly raised error wins over a W1C clear landing in the same cycle.
    cmderr_d = cmderr_q;
    if (acs_wr) cmderr_d = cmderr_e'(cmderr_q & ~acs_wdata[10:8]);
    if (w_err_set && cmderr_q == CMDERR_NONE) cmderr_d = w_err_val;
  end

  always_comb begin
    w_acs           = '0;
    w_acs.busy      = w_busy;
    w_acs.cmderr    = cmderr_q;
    w_acs.datacount = 4'(DATACOUNT);
    acs_rdata       = w_acs;
    data0_rdata     = data0_q;
    reg_req         = (state_q == ST_REQ);
    reg_we          = reg_we_q;
    reg_is_csr      = reg_is_csr_q;
    reg_addr        = reg_addr_q;
    reg_wdata       = data0_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_abstract_cmd_ctrl.sv
`default_nettype none
// tb_dm_abstract_cmd_ctrl: directed and random command sequences checked
// against a command-level reference model.
module tb_dm_abstract_cmd_ctrl;

  localparam int TIMEOUT   = 255;
  localparam int DATACOUNT = 3;

  logic        clk = 1'b0;
  logic        rst_n, dmactive, cmd_wr, acs_wr, data0_wr, hart_halted;
  logic [31:0] cmd_wdata, acs_wdata, data0_wdata, acs_rdata, data0_rdata;
  logic        reg_req, reg_we, reg_is_csr, reg_ack, reg_err;
  logic [11:0] reg_addr;
  logic [31:0] reg_wdata, reg_rdata;

  always #5 clk = ~clk;

  dm_abstract_cmd_ctrl #(.TIMEOUT(TIMEOUT), .DATACOUNT(DATACOUNT)) dut (
    .clk(clk), .rst_n(rst_n), .dmactive(dmactive),
    .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
    .acs_wr(acs_wr), .acs_wdata(acs_wdata), .acs_rdata(acs_rdata),
    .data0_wr(data0_wr), .data0_wdata(data0_wdata), .data0_rdata(data0_rdata),
    .hart_halted(hart_halted),
    .reg_req(reg_req), .reg_we(reg_we), .reg_is_csr(reg_is_csr),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata),
    .reg_ack(reg_ack), .reg_err(reg_err), .reg_rdata(reg_rdata)
  );

  int          tests_run    = 0;
  int          tests_failed = 0;
  logic [31:0] m_data0;
  int          m_cmderr;
  logic [15:0] m_regno;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ":acs"}, acs_rdata, {19'd0, 1'b0, 1'b0, 3'(m_cmderr), 4'd0, 4'(DATACOUNT)});
    check_eq({tag, ":data0"}, data0_rdata, m_data0);
    check_eq({tag, ":regno"}, {16'd0, dut.cmd_q.control.regno}, {16'd0, m_regno});
  endtask

  task automatic write_data0(input logic [31:0] v);
    data0_wr = 1'b1; data0_wdata = v;
    tick;
    data0_wr = 1'b0;
    m_data0 = v;
  endtask

  task automatic clear_err;
    acs_wr = 1'b1; acs_wdata = 32'h0000_0700;
    tick;
    acs_wr = 1'b0;
    m_cmderr = 0;
    check_eq("w1c_clear", {29'd0, acs_rdata[10:8]}, 32'd0);
  endtask

  // Expected outcome of the validation rules for one command.
  function automatic void model_decode(input logic [31:0] cmd, input bit halted,
                                       output int err, output bit req,
                                       output bit csr, output logic [11:0] addr);
    logic [15:0] r;
    r = cmd[15:0];
    err = 0; req = 1'b0; csr = 1'b0; addr = '0;
    if (cmd[31:24] != 8'd0 || cmd[18] || (cmd[17] && cmd[22:20] != 3'd2)) err = 2;
    else if (!cmd[17]) err = 0;
    else if (!halted) err = 4;
    else if (r >= 16'h1000 && r <= 16'h101F) begin req = 1'b1; addr = {7'd0, r[4:0]}; end
    else if (r <= 16'h0FFF) begin req = 1'b1; csr = 1'b1; addr = r[11:0]; end
    else err = 3;
  endfunction

  task automatic run_cmd(input logic [31:0] cmd, input bit halted, input int dly,
                         input bit aerr, input logic [31:0] rdata, input bit no_ack,
                         input bit poke);
    int          exp_err, ferr, cyc, nreq, exp_lat, exp_nreq;
    bit          exp_req, exp_csr, accepted;
    logic [11:0] exp_addr;
    model_decode(cmd, halted, exp_err, exp_req, exp_csr, exp_addr);
    accepted    = (m_cmderr == 0);
    hart_halted = halted;
    cmd_wdata   = cmd;
    cmd_wr      = 1'b1;
    tick;
    cmd_wr = 1'b0;
    check_eq("busy_rise", {31'd0, acs_rdata[12]}, {31'd0, accepted});
    if (!accepted) begin
      check_state("ignored");
      return;
    end
    m_regno = cmd[15:0];
    cyc = 1; nreq = 0;
    while (acs_rdata[12] && cyc < 600) begin
      if (reg_req) begin
        nreq++;
        if (nreq == 1) begin
          check_eq("req_we",    {31'd0, reg_we},     {31'd0, cmd[16]});
          check_eq("req_csr",   {31'd0, reg_is_csr}, {31'd0, exp_csr});
          check_eq("req_addr",  {20'd0, reg_addr},   {20'd0, exp_addr});
          check_eq("req_wdata", reg_wdata, m_data0);
          if (poke) begin
            cmd_wr = 1'b1; cmd_wdata = $urandom;
            data0_wr = 1'b1; data0_wdata = $urandom;
            if (m_cmderr == 0) m_cmderr = 1;
          end
        end
        if (!no_ack && nreq == dly + 1) begin
          reg_ack = 1'b1; reg_err = aerr; reg_rdata = rdata;
        end
      end
      tick;
      cmd_wr = 1'b0; data0_wr = 1'b0; reg_ack = 1'b0; reg_err = 1'b0;
      cyc++;
    end
    check_eq("busy_fall", {31'd0, acs_rdata[12]}, 32'd0);
    if (exp_req) begin
      exp_nreq = no_ack ? TIMEOUT : dly + 1;
      exp_lat  = no_ack ? TIMEOUT + 3 : dly + 4;
      if (no_ack || aerr) ferr = 3;
      else begin
        ferr = 0;
        if (!cmd[16]) m_data0 = rdata;
      end
    end else begin
      exp_nreq = 0;
      exp_lat  = 3;
      ferr     = exp_err;
    end
    check_eq("req_cycles", nreq, exp_nreq);
    check_eq("latency", cyc, exp_lat);
    if (m_cmderr == 0) m_cmderr = ferr;
    if (cmd[19] && m_cmderr == 0) m_regno = m_regno + 16'd1;
    check_state("cmd_end");
    if (no_ack && exp_req) begin
      reg_ack = 1'b1; reg_rdata = ~m_data0;
      tick;
      reg_ack = 1'b0;
      check_eq("late_ack_req", {31'd0, reg_req}, 32'd0);
      check_state("late_ack");
    end
  endtask

  initial begin
    logic [31:0] cmd;
    logic [15:0] regno;
    rst_n = 1'b0; dmactive = 1'b1; cmd_wr = 1'b0; acs_wr = 1'b0; data0_wr = 1'b0;
    cmd_wdata = '0; acs_wdata = '0; data0_wdata = '0; hart_halted = 1'b1;
    reg_ack = 1'b0; reg_err = 1'b0; reg_rdata = '0;
    m_data0 = '0; m_cmderr = 0; m_regno = '0;
    tick; tick;
    rst_n = 1'b1;
    check_eq("rst_req",  {31'd0, reg_req},    32'd0);
    check_eq("rst_we",   {31'd0, reg_we},     32'd0);
    check_eq("rst_csr",  {31'd0, reg_is_csr}, 32'd0);
    check_eq("rst_addr", {20'd0, reg_addr},   32'd0);
    check_state("reset");

    write_data0(32'hDEAD_BEEF);
    run_cmd(32'h0023_1005, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cmd(32'h0022_1300, 1'b1, 2, 1'b0, 32'h0000_1800, 1'b0, 1'b0);
    run_cmd(32'h002A_1300, 1'b1, 1, 1'b0, 32'h0000_1800, 1'b0, 1'b0);
    run_cmd(32'h0022_1001, 1'b0, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    clear_err;
    run_cmd(32'h0100_0000, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cmd(32'h0023_1005, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    clear_err;
    run_cmd(32'h0022_1002, 1'b1, 0, 1'b0, 32'h1234_5678, 1'b1, 1'b0);
    clear_err;
    run_cmd(32'h0022_0341, 1'b1, 3, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b1);
    clear_err;
    run_cmd(32'h0008_FFFF, 1'b1, 0, 1'b0, 32'h0, 1'b0, 1'b0);
    run_cmd(32'h0022_1010, 1'b1, 0, 1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    clear_err;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       regno = 16'h1000 + 16'($urandom_range(0, 31));
        1:       regno = 16'($urandom_range(0, 32'h0FFF));
        2:       regno = 16'($urandom_range(32'h1020, 32'hFFFF));
        default: regno = $urandom_range(0, 1) ? 16'h101F : 16'h0FFF;
      endcase
      cmd = {($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'd0, 1'b0,
             ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'd2,
             1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) != 0),
             1'($urandom), regno};
      if (m_cmderr != 0 && $urandom_range(0, 3) != 0) clear_err;
      if ($urandom_range(0, 1) == 1) write_data0($urandom);
      run_cmd(cmd, ($urandom_range(0, 4) != 0), $urandom_range(1, 5),
              ($urandom_range(0, 5) == 0), $urandom,
              ($urandom_range(0, 14) == 0), ($urandom_range(0, 7) == 0));
    end

    if (m_cmderr != 0) clear_err;
    write_data0(32'h1234_5678);
    hart_halted = 1'b1;
    cmd_wdata = 32'h0023_1005; cmd_wr = 1'b1;
    tick;
    cmd_wr = 1'b0;
    tick;
    check_eq("dm_req_before", {31'd0, reg_req}, 32'd1);
    dmactive = 1'b0;
    tick;
    dmactive = 1'b1;
    m_data0 = '0; m_cmderr = 0; m_regno = '0;
    check_eq("dm_req",  {31'd0, reg_req},    32'd0);
    check_eq("dm_we",   {31'd0, reg_we},     32'd0);
    check_eq("dm_csr",  {31'd0, reg_is_csr}, 32'd0);
    check_eq("dm_addr", {20'd0, reg_addr},   32'd0);
    check_state("dmactive");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
